// File: rtl/seq_detect_ctrl_if.sv
// Producer and consumer handshakes of the sequence-detector controller.
// The master side is the host; the slave side is the controller itself.
interface seq_detect_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_clear;
    logic             in_ready;
    logic             res_valid;
    logic [CNT_W-1:0] res_count;
    logic             res_ready;

    modport master (
        output in_valid, in_data, in_clear, res_ready,
        input  in_ready, res_valid, res_count
    );

    modport slave (
        input  in_valid, in_data, in_clear, res_ready,
        output in_ready, res_valid, res_count
    );
endinterface

// File: rtl/seq_detect_ctrl.sv
// Serializes parallel words MSB-first into a Mealy sequence detector
// and returns the saturating count of detector pulses per word.
module seq_detect_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    seq_detect_ctrl_if.slave   bus,
    output logic               det_d,
    output logic               det_rst,
    input  logic               det_out,
    output logic               busy
);
    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CLR, SHIFT, REPORT} state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [WIDTH-1:0]   r_shiftReg;
    logic [BIT_W-1:0]   r_bitCnt;
    logic [CNT_W-1:0]   r_matchCnt;

    // det_out is sampled at the edge that closes each SHIFT cycle, i.e. the
    // Mealy response to the bit currently on det_d.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_shiftReg <= '0;
            r_bitCnt   <= '0;
            r_matchCnt <= '0;
        end else begin
            r_state <= w_nextState;
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_shiftReg <= bus.in_data;
                        r_bitCnt   <= '0;
                        r_matchCnt <= '0;
                    end
                end
                SHIFT: begin
                    r_shiftReg <= r_shiftReg << 1;
                    r_bitCnt   <= r_bitCnt + 1'b1;
                    if (det_out && (r_matchCnt != CNT_MAX)) begin
                        r_matchCnt <= r_matchCnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        w_nextState   = r_state;
        det_d         = 1'b0;
        det_rst       = rst;
        bus.in_ready  = 1'b0;
        bus.res_valid = 1'b0;
        case (r_state)
            IDLE: begin
                bus.in_ready = ~rst;
                if (bus.in_valid) begin
                    w_nextState = bus.in_clear ? CLR : SHIFT;
                end
            end
            CLR: begin
                det_rst     = 1'b1;
                w_nextState = SHIFT;
            end
            SHIFT: begin
                det_d = r_shiftReg[WIDTH-1];
                if (r_bitCnt == LAST_BIT) begin
                    w_nextState = REPORT;
                end
            end
            REPORT: begin
                bus.res_valid = 1'b1;
                if (bus.res_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    assign bus.res_count = r_matchCnt;
    assign busy          = (r_state != IDLE);
endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Randomized bench for seq_detect_ctrl: a 4-bit and a 2-bit counter instance
// run in lockstep against a popcount / bit-history reference model.
module tb_seq_detect_ctrl;
    localparam int WIDTH = 8;

    logic clk;
    logic rst;
    logic det_d4, det_rst4, det_out4, busy4;
    logic det_d2, det_rst2, det_out2, busy2;

    seq_detect_ctrl_if #(.WIDTH(WIDTH), .CNT_W(4)) ifc4 ();
    seq_detect_ctrl_if #(.WIDTH(WIDTH), .CNT_W(2)) ifc2 ();

    seq_detect_ctrl #(.WIDTH(WIDTH), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .bus(ifc4.slave),
        .det_d(det_d4), .det_rst(det_rst4), .det_out(det_out4), .busy(busy4)
    );

    seq_detect_ctrl #(.WIDTH(WIDTH), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .bus(ifc2.slave),
        .det_d(det_d2), .det_rst(det_rst2), .det_out(det_out2), .busy(busy2)
    );

    assign ifc2.in_valid  = ifc4.in_valid;
    assign ifc2.in_data   = ifc4.in_data;
    assign ifc2.in_clear  = ifc4.in_clear;
    assign ifc2.res_ready = ifc4.res_ready;

    // Stand-in for the team's "1011" overlapping Mealy detector.
    logic [2:0] detHist;
    bit         stubMode;
    always @(posedge clk or posedge det_rst4) begin
        if (det_rst4) detHist <= 3'b000;
        else          detHist <= {detHist[1:0], det_d4};
    end
    assign det_out4 = stubMode ? det_d4 : ((detHist == 3'b101) && det_d4);
    assign det_out2 = det_d2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int k = 0;
    int cycleNo = 0;
    int acceptCycle = 0;
    int waitCycles = 0;
    int shiftLeft = 0;
    bit phaseClr = 0;
    bit holdValid = 0;
    logic [WIDTH-1:0] curWord;
    int model4 = 0;
    int model2 = 0;
    bit hist[$];

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed %0d expected %0d (cycle %0d)", tag, observed, expected, cycleNo);
        end
    endtask

    // Advances to the next falling edge and runs the reference model there.
    task automatic stepCycle();
        bit expRst;
        bit match;
        @(negedge clk);
        k++;
        cycleNo++;
        expRst = phaseClr;
        if (phaseClr) begin
            checkOutput("det_d_clr", det_d4, 0);
            phaseClr = 0;
        end else if (shiftLeft > 0) begin
            checkOutput("det_d_bit", det_d4, int'(curWord[shiftLeft-1]));
            shiftLeft--;
            match = (hist.size() == 3) && hist[0] && !hist[1] && hist[2] && (det_d4 == 1'b1);
            if (!stubMode && match && model4 < 15) model4++;
        end
        checkOutput("det_rst", det_rst4, int'(expRst));
        if (det_rst4) begin
            hist.delete();
        end else begin
            hist.push_back(det_d4);
            if (hist.size() > 3) void'(hist.pop_front());
        end
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] w, input bit clr, input bit stub);
        int ones;
        ifc4.in_valid = 1'b1;
        ifc4.in_data  = w;
        ifc4.in_clear = clr;
        waitCycles = 0;
        while (!ifc4.in_ready && waitCycles < 50) begin
            stepCycle();
            waitCycles++;
        end
        if (waitCycles >= 50) checkOutput("accept_timeout", ifc4.in_ready, 1);
        acceptCycle = cycleNo;
        ones = $countones(w);
        phaseClr  = clr;
        shiftLeft = WIDTH;
        curWord   = w;
        stubMode  = stub;
        model4    = stub ? ((ones > 15) ? 15 : ones) : 0;
        model2    = (ones > 3) ? 3 : ones;
        k = 0;
        stepCycle();
        if (!holdValid) ifc4.in_valid = 1'b0;
        ifc4.in_data  = WIDTH'($urandom);
        ifc4.in_clear = 1'($urandom);
    endtask

    task automatic collectResult(input int hold, input bit keepReady, input bit clr);
        ifc4.res_ready = (hold == 0);
        while (!ifc4.res_valid && k < 40) stepCycle();
        checkOutput("latency", k, WIDTH + 1 + int'(clr));
        checkOutput("count4", ifc4.res_count, model4);
        checkOutput("count2", ifc2.res_count, model2);
        for (int i = 0; i < hold; i++) begin
            stepCycle();
            checkOutput("bp_valid", ifc4.res_valid, 1);
            checkOutput("bp_count", ifc4.res_count, model4);
            checkOutput("bp_busy", busy4, 1);
            checkOutput("bp_in_ready", ifc4.in_ready, 0);
        end
        ifc4.res_ready = 1'b1;
        if (!keepReady) begin
            stepCycle();
            ifc4.res_ready = 1'b0;
            checkOutput("res_valid_drop", ifc4.res_valid, 0);
            checkOutput("count_hold", ifc4.res_count, model4);
            checkOutput("busy_idle", busy4, 0);
        end
    endtask

    initial begin
        int prevAccept;
        logic [WIDTH-1:0] wordA;
        logic [WIDTH-1:0] wordB;
        rst = 1'b1;
        stubMode = 1'b1;
        ifc4.in_valid  = 1'b0;
        ifc4.in_data   = '0;
        ifc4.in_clear  = 1'b0;
        ifc4.res_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_det_rst", det_rst4, 1);
        checkOutput("rst_det_d", det_d4, 0);
        checkOutput("rst_in_ready", ifc4.in_ready, 0);
        checkOutput("rst_res_valid", ifc4.res_valid, 0);
        checkOutput("rst_res_count", ifc4.res_count, 0);
        checkOutput("rst_busy", busy4, 0);
        rst = 1'b0;
        #1;
        checkOutput("in_ready_first", ifc4.in_ready, 1);

        $display("[TB] popcount and saturation");
        applyStimulus(8'hB5, 1, 1);
        collectResult(0, 0, 1);
        applyStimulus(8'hFF, 0, 1);
        collectResult(0, 0, 0);
        applyStimulus(8'h00, 0, 1);
        collectResult(0, 0, 0);

        $display("[TB] backpressure with pending word");
        applyStimulus(8'h3C, 0, 1);
        ifc4.in_valid = 1'b1;
        ifc4.in_data  = 8'h81;
        collectResult(7, 1, 0);
        applyStimulus(8'h81, 1, 1);
        checkOutput("pending_wait", waitCycles, 1);
        collectResult(0, 0, 1);

        $display("[TB] detector with and without clear");
        wordA = 8'hB5;
        wordB = WIDTH'($urandom);
        for (int pass = 0; pass < 2; pass++) begin
            applyStimulus(wordA, 1, 0);
            collectResult(0, 0, 1);
            applyStimulus(wordB, pass[0], 0);
            collectResult(0, 0, pass[0]);
        end

        $display("[TB] mid-operation reset");
        applyStimulus(8'hA7, 0, 1);
        repeat (3) stepCycle();
        #1 rst = 1'b1;
        #1;
        checkOutput("abort_det_rst", det_rst4, 1);
        checkOutput("abort_busy", busy4, 0);
        checkOutput("abort_res_valid", ifc4.res_valid, 0);
        checkOutput("abort_count", ifc4.res_count, 0);
        #1 rst = 1'b0;
        shiftLeft = 0;
        phaseClr  = 0;
        hist.delete();
        #1;
        checkOutput("abort_in_ready", ifc4.in_ready, 1);
        applyStimulus(8'h01, 0, 1);
        collectResult(0, 0, 0);

        $display("[TB] back-to-back");
        holdValid = 1'b1;
        prevAccept = 0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(WIDTH'($urandom), 0, 1);
            if (i > 0) checkOutput("b2b_gap", acceptCycle - prevAccept, WIDTH + 2);
            prevAccept = acceptCycle;
            collectResult(0, 1, 0);
        end
        holdValid = 1'b0;
        ifc4.in_valid = 1'b0;
        stepCycle();
        ifc4.res_ready = 1'b0;

        $display("[TB] random words");
        for (int i = 0; i < 16; i++) begin
            bit clr;
            clr = 1'($urandom);
            applyStimulus(WIDTH'($urandom), clr, 1'($urandom));
            collectResult($urandom_range(0, 3), 0, clr);
            repeat ($urandom_range(0, 2)) stepCycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/seq_detect_ctrl.md
# seq_detect_ctrl

Sequencing controller for the team's serial Mealy sequence detector. It accepts parallel words over a valid/ready handshake and optionally resets the detector between words. It shifts each word MSB-first into the detector's `d` input, one bit per clock, and counts the detector's `out` pulses. At the end of each word it returns the match count over a second valid/ready handshake. It sits between a parallel producer (host/BRAM reader) and one detector instance.

## Interface
Parameters:
- `WIDTH`, 8, bits per input word; legal range 2..32.
- `CNT_W`, 4, width of the match counter; legal range 1..6.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: producer has a word.
- `in_data` in WIDTH: word to serialize; bit WIDTH-1 is sent first.
- `in_clear` in 1: sampled with the word; 1 resets the detector before this word, 0 continues detector state from the previous word.
- `in_ready` out 1: controller accepts a word this cycle.
- `det_d` out 1: serial bit to detector `d`.
- `det_rst` out 1: reset to detector `rst`.
- `det_out` in 1: detector Mealy output.
- `res_valid` out 1: match count available.
- `res_count` out CNT_W: matches found in the last word; saturating.
- `res_ready` in 1: consumer takes the result.
- `busy` out 1: high in any state other than IDLE.

## Operation
The controller is a four-state FSM: IDLE, CLR, SHIFT, REPORT.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`&`in_ready`: latch `in_data` into the shift register, clear the bit counter and the match counter to 0.
  - Next state is CLR if `in_clear`=1, else SHIFT.
- **CLR**
  - `det_rst`=1 for exactly one cycle.
  - `det_d`=0.
  - Next state is SHIFT.
- **SHIFT**
  - `det_d` = shift register MSB.
  - Each cycle: if `det_out`=1, the match counter increments; the shift register shifts left and the bit counter increments.
  - After WIDTH SHIFT cycles, go to REPORT.
- **REPORT**
  - `res_valid`=1 and `res_count` holds the final count.
  - On `res_valid`&`res_ready`: return to IDLE.
- Match counter saturates at 2^CNT_W-1 and never wraps.
- `det_d`=0 and `det_rst`=0 in IDLE and REPORT, so the detector idles on zeros. With `in_clear`=0 the detector keeps the state it reached after the trailing idle zeros, not the state after the last data bit. This is intended; producers needing strict continuity must send back-to-back words.
- `busy` = (state != IDLE).

## Timing
- **Reset values:**
  - state IDLE; `det_rst`=1 while `rst` is high.
  - `det_d`=0, `res_valid`=0, `res_count`=0, `busy`=0, `in_ready`=0 while `rst` is high.
  - After `rst` falls, `in_ready`=1 from the first cycle.
- **Mid-operation reset:** asserting `rst` in any state aborts immediately. No result is produced, and the partial count is discarded.
- **Outputs:** `det_d`, `det_rst`, `in_ready`, `res_valid` and `busy` are decoded from registered state only. No combinational path runs from `in_valid`, `det_out` or `res_ready` to any output.
- **Sampling:** `det_out` is sampled at the rising edge that ends each SHIFT cycle. This captures the Mealy output for the bit currently driven.
- **Latency:** accept edge to first `res_valid`:
  - WIDTH+1 cycles with `in_clear`=0;
  - WIDTH+2 cycles with `in_clear`=1.
- **Throughput:** at most one word per WIDTH+2 cycles (+1 with clear), since IDLE costs one cycle.
- **Handshake rules:**
  - `in_data` and `in_clear` are ignored unless `in_valid`&`in_ready`.
  - `res_valid` and `res_count` stay stable while `res_ready`=0; backpressure is unbounded.
  - `res_count` holds its value after the handshake until the next accept clears it.
- **Simultaneous events:** `in_valid` high during REPORT is not accepted (`in_ready`=0). The word is accepted one cycle after the result handshake.

## Test plan
1. **Popcount, WIDTH=8, CNT_W=4:** use a bench stub with `det_out`=`det_d`. Accept 8'hB5 with `in_clear`=1.
   - `det_rst` is high exactly one cycle.
   - `det_d` sequence is 1,0,1,1,0,1,0,1.
   - `res_count`=5 with `res_valid` 10 cycles after the accept edge.
2. **Saturation, CNT_W=2, stub as in 1:** accept 8'hFF → `res_count`=3. Then 8'h00 → `res_count`=0.
3. **Backpressure:** hold `res_ready`=0 for 7 cycles.
   - `res_valid`=1, and `res_count` and `busy`=1 stay constant.
   - A pending `in_valid` is not accepted until the cycle after the `res_ready` handshake.
4. **Real detector, `in_clear`=0 vs 1:** instantiate the team's Mealy detector and send the same two words twice, once with each clear setting. Counts must match a bench behavioural model fed the identical `det_d`/`det_rst` stream, including the idle zeros.
5. **Mid-operation reset:** pulse `rst` in the 4th SHIFT cycle.
   - Asynchronously `det_rst`=1, `busy`=0, `res_valid`=0.
   - After release, a fresh 8'h01 word reports 1 with the stub.
6. **Back-to-back, stub as in 1:** hold `in_valid`=1 with 3 words and `res_ready`=1 throughout. Accept edges are exactly WIDTH+2 cycles apart with `in_clear`=0, and each count is correct.
